// File: rtl/hash_des_stream.sv
// Byte-stream Feistel hash engine: absorbs a length-declared message over valid/ready and emits a digest.
// Define HASH_DES_UNROLL_EN to evaluate all rounds of a byte in one cycle instead of one round per cycle.
module hash_des_stream #(
   parameter int BYTES_PER_BEAT = 1,
   parameter int DIGEST_W       = 32,
   parameter int ROUNDS         = 4,
   parameter int LEN_W          = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [LEN_W-1:0]            msg_len,
   input  logic                        m_valid,
   input  logic [8*BYTES_PER_BEAT-1:0] m_data,
   input  logic [BYTES_PER_BEAT-1:0]   m_keep,
   output logic                        m_ready,
   output logic                        busy,
   output logic                        hash_ready,
   output logic [DIGEST_W-1:0]         digest,
   output logic                        len_err
);

   localparam int HW        = DIGEST_W / 2;
   localparam int LEN_BYTES = LEN_W / 8;
   localparam int MAXB      = (BYTES_PER_BEAT > LEN_BYTES) ? BYTES_PER_BEAT : LEN_BYTES;
   localparam int IDX_W     = $clog2(MAXB + 1);
   localparam logic [HW-1:0]       K_CONST = {(HW/16){16'h9E37}};
   localparam logic [DIGEST_W-1:0] IV      = {(DIGEST_W/32){32'h67452301}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_ABSORB,
      S_COMPRESS,
      S_FINAL,
      S_DONE
   } state_t;

   // One Feistel round; rotation is taken from the upper half of {x,x} shifted left.
   function automatic logic [DIGEST_W-1:0] des_round(
      input logic [HW-1:0] l,
      input logic [HW-1:0] r,
      input logic [7:0]    b,
      input int            rnd
   );
      logic [HW-1:0]   x;
      logic [2*HW-1:0] dbl;
      logic [HW-1:0]   f;
      x   = r ^ {(HW/8){b}};
      dbl = {x, x} << (rnd + 1);
      f   = dbl[2*HW-1:HW] + (K_CONST ^ HW'(rnd));
      return {r, l ^ f};
   endfunction

   state_t                      state_reg, state_next;
   logic [HW-1:0]               l_reg, l_next;
   logic [HW-1:0]               r_reg, r_next;
   logic [LEN_W-1:0]            remain_reg, remain_next;
   logic [LEN_W-1:0]            len_reg, len_next;
   logic [8*BYTES_PER_BEAT-1:0] beat_reg, beat_next;
   logic [IDX_W-1:0]            kept_reg, kept_next;
   logic [IDX_W-1:0]            byte_idx_reg, byte_idx_next;
   logic                        len_err_reg, len_err_next;

   logic [7:0]          cur_byte;
   logic [DIGEST_W-1:0] round_out;
   logic                last_round;
   logic                step;
   logic                last_byte;
   logic [IDX_W-1:0]    pop;
   logic [IDX_W-1:0]    kept;
   logic                over;

   assign step = (state_reg == S_COMPRESS) || (state_reg == S_FINAL);

   always_comb begin
      cur_byte = '0;
      for (int i = 0; i < BYTES_PER_BEAT; i++) begin
         if (state_reg != S_FINAL && byte_idx_reg == IDX_W'(i))
            cur_byte = beat_reg[8*i +: 8];
      end
      // The length is absorbed LSB-first once the message bytes are done.
      for (int i = 0; i < LEN_BYTES; i++) begin
         if (state_reg == S_FINAL && byte_idx_reg == IDX_W'(i))
            cur_byte = len_reg[8*i +: 8];
      end
   end

`ifdef HASH_DES_UNROLL_EN
   logic [DIGEST_W-1:0] chain [ROUNDS+1];

   assign chain[0] = {l_reg, r_reg};
   for (genvar gi = 0; gi < ROUNDS; gi++) begin : g_round
      assign chain[gi+1] = des_round(chain[gi][DIGEST_W-1:HW], chain[gi][HW-1:0], cur_byte, gi);
   end
   assign round_out  = chain[ROUNDS];
   assign last_round = 1'b1;
`else
   localparam int RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

   logic [RND_W-1:0] rnd_reg, rnd_next;

   assign round_out  = des_round(l_reg, r_reg, cur_byte, int'(rnd_reg));
   assign last_round = (rnd_reg == RND_W'(ROUNDS - 1));

   always_comb begin
      rnd_next = '0;
      if (step && !last_round)
         rnd_next = rnd_reg + RND_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         rnd_reg <= '0;
      else
         rnd_reg <= rnd_next;
   end
`endif

   // Kept bytes are clipped to what the declared length still allows.
   always_comb begin
      pop = '0;
      for (int i = 0; i < BYTES_PER_BEAT; i++)
         pop = pop + IDX_W'(m_keep[i]);
      over = 1'b0;
      kept = pop;
      if (LEN_W'(pop) > remain_reg) begin
         over = 1'b1;
         kept = IDX_W'(remain_reg);
      end
   end

   assign last_byte = (state_reg == S_FINAL) ? (byte_idx_reg == IDX_W'(LEN_BYTES - 1))
                                             : (byte_idx_reg == kept_reg - IDX_W'(1));

   always_comb begin
      state_next    = state_reg;
      l_next        = l_reg;
      r_next        = r_reg;
      remain_next   = remain_reg;
      len_next      = len_reg;
      beat_next     = beat_reg;
      kept_next     = kept_reg;
      byte_idx_next = byte_idx_reg;
      len_err_next  = len_err_reg;
      case (state_reg)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_next    = (msg_len == '0) ? S_FINAL : S_ABSORB;
               l_next        = IV[DIGEST_W-1:HW];
               r_next        = IV[HW-1:0];
               remain_next   = msg_len;
               len_next      = msg_len;
               len_err_next  = 1'b0;
               byte_idx_next = '0;
            end
         end
         S_ABSORB: begin
            // remain is nonzero here, so any beat with a kept byte absorbs at least one.
            if (m_valid && pop != '0) begin
               beat_next     = m_data;
               kept_next     = kept;
               remain_next   = remain_reg - LEN_W'(kept);
               len_err_next  = len_err_reg | over;
               byte_idx_next = '0;
               state_next    = S_COMPRESS;
            end
         end
         S_COMPRESS, S_FINAL: begin
            l_next = round_out[DIGEST_W-1:HW];
            r_next = round_out[HW-1:0];
            if (last_round) begin
               if (last_byte) begin
                  byte_idx_next = '0;
                  if (state_reg == S_FINAL)
                     state_next = S_DONE;
                  else
                     state_next = (remain_reg == '0) ? S_FINAL : S_ABSORB;
               end else begin
                  byte_idx_next = byte_idx_reg + IDX_W'(1);
               end
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         l_reg        <= '0;
         r_reg        <= '0;
         remain_reg   <= '0;
         len_reg      <= '0;
         beat_reg     <= '0;
         kept_reg     <= '0;
         byte_idx_reg <= '0;
         len_err_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         l_reg        <= l_next;
         r_reg        <= r_next;
         remain_reg   <= remain_next;
         len_reg      <= len_next;
         beat_reg     <= beat_next;
         kept_reg     <= kept_next;
         byte_idx_reg <= byte_idx_next;
         len_err_reg  <= len_err_next;
      end
   end

   assign m_ready    = (state_reg == S_ABSORB);
   assign busy       = step || (state_reg == S_ABSORB);
   assign hash_ready = (state_reg == S_DONE);
   assign digest     = hash_ready ? {l_reg, r_reg} : '0;
   assign len_err    = len_err_reg;

endmodule

// File: tb/tb_hash_des_stream.sv
// Bench for hash_des_stream: a 1-byte-beat and a 4-byte-beat instance checked against a golden model.
module tb_hash_des_stream;

   localparam int ROUNDS = 4;
`ifdef HASH_DES_UNROLL_EN
   localparam int RPC = 1;
`else
   localparam int RPC = ROUNDS;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, m_valid;
   logic [63:0] msg_len;
   logic [7:0]  m_data;
   logic [0:0]  m_keep;
   logic        m_ready, busy, hash_ready, len_err;
   logic [31:0] digest;

   logic        start4, m_valid4;
   logic [63:0] msg_len4;
   logic [31:0] m_data4;
   logic [3:0]  m_keep4;
   logic        m_ready4, busy4, hash_ready4, len_err4;
   logic [31:0] digest4;

   hash_des_stream u_dut (
      .clk(clk), .rst(rst), .start(start), .msg_len(msg_len),
      .m_valid(m_valid), .m_data(m_data), .m_keep(m_keep), .m_ready(m_ready),
      .busy(busy), .hash_ready(hash_ready), .digest(digest), .len_err(len_err)
   );

   hash_des_stream #(.BYTES_PER_BEAT(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .msg_len(msg_len4),
      .m_valid(m_valid4), .m_data(m_data4), .m_keep(m_keep4), .m_ready(m_ready4),
      .busy(busy4), .hash_ready(hash_ready4), .digest(digest4), .len_err(len_err4)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: message bytes (i or 'A'), then 8 length bytes LSB-first, ROUNDS rounds each.
   function automatic logic [31:0] golden(input int len, input int mode);
      logic [15:0] l, r, x, f, rot, nl;
      logic [31:0] t;
      logic [7:0]  b;
      logic [63:0] lv;
      l  = 16'h6745;
      r  = 16'h2301;
      lv = 64'(len);
      for (int i = 0; i < len + 8; i++) begin
         if (i < len) b = (mode != 0) ? 8'h41 : 8'(i);
         else         b = 8'(lv >> (8 * (i - len)));
         for (int k = 0; k < ROUNDS; k++) begin
            x   = r ^ {b, b};
            t   = {16'h0000, x};
            rot = 16'((t << (k + 1)) | (t >> (16 - (k + 1))));
            f   = rot + (16'h9E37 ^ 16'(k));
            nl  = r;
            r   = l ^ f;
            l   = nl;
         end
      end
      return {l, r};
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      int w;
      w = 0;
      while (!m_ready && w < 2000) begin
         if (gap > 0) begin
            m_valid = ~m_valid;
            m_data  = 8'hA5;
         end
         @(negedge clk);
         w++;
      end
      m_valid = 1'b0;
      if (w >= 2000) begin
         n_checks++;
         $display("FAIL ready_timeout: m_ready stayed %0b, required 1", m_ready);
      end else begin
         for (int g = 0; g < gap; g++) @(negedge clk);
         m_valid = 1'b1;
         m_data  = b;
         m_keep  = 1'b1;
         @(negedge clk);
         m_valid = 1'b0;
         m_data  = '0;
      end
   endtask

   task automatic wait_done(output int lat, output bit mr_seen);
      lat     = 1;
      mr_seen = 0;
      while (!hash_ready && lat < 2000) begin
         if (m_ready) mr_seen = 1;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_msg(input int len, input int mode, input int gap,
                          output logic [31:0] dig, output int lat, output logic err,
                          output bit mr_seen, output bit start_ok);
      @(negedge clk);
      start   = 1'b1;
      msg_len = 64'(len);
      @(negedge clk);
      start    = 1'b0;
      start_ok = busy && !hash_ready && (digest == '0);
      for (int i = 0; i < len; i++)
         send_byte((mode != 0) ? 8'h41 : 8'(i), gap);
      wait_done(lat, mr_seen);
      dig = digest;
      err = len_err;
   endtask

   task automatic run4(input bit full_keep, input bit empty_beat,
                       output logic [31:0] dig, output int lat, output logic err_now,
                       output logic err_end, output logic rdy_after_empty);
      int w;
      @(negedge clk);
      start4   = 1'b1;
      msg_len4 = 64'd50;
      @(negedge clk);
      start4          = 1'b0;
      err_now         = 1'b0;
      rdy_after_empty = 1'b1;
      for (int j = 0; j < 13; j++) begin
         w = 0;
         while (!m_ready4 && w < 2000) begin
            @(negedge clk);
            w++;
         end
         if (empty_beat && j == 5) begin
            m_valid4 = 1'b1;
            m_data4  = 32'hFFFF_FFFF;
            m_keep4  = 4'b0000;
            @(negedge clk);
            rdy_after_empty = m_ready4;
         end
         m_valid4 = 1'b1;
         m_data4  = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
         m_keep4  = (j < 12 || full_keep) ? 4'b1111 : 4'b0011;
         @(negedge clk);
         m_valid4 = 1'b0;
      end
      err_now = len_err4;
      lat = 1;
      while (!hash_ready4 && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
      dig     = digest4;
      err_end = len_err4;
   endtask

   typedef struct {
      int          msg_len;
      int          mode;
      int          gap;
      logic [31:0] exp_digest;
      int          exp_lat;
   } vec_t;

   vec_t        vecs [7];
   logic [31:0] digs [7];

   initial begin : main
      logic [31:0] dig;
      int          lat;
      logic        err, err_now, rdy;
      bit          mr_seen, start_ok;

      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [31:0] dig;
      int          lat;
      logic        err, err_now, rdy;
      bit          mr_seen, start_ok;

      vecs[0] = '{0,  0, 0, 32'h0, 0};
      vecs[1] = '{1,  1, 0, 32'h0, 0};
      vecs[2] = '{50, 0, 0, 32'h0, 0};
      vecs[3] = '{50, 0, 2, 32'h0, 0};
      vecs[4] = '{49, 0, 0, 32'h0, 0};
      vecs[5] = '{8,  0, 1, 32'h0, 0};
      vecs[6] = '{2,  1, 0, 32'h0, 0};
      for (int i = 0; i < 7; i++) begin
         vecs[i].exp_digest = golden(vecs[i].msg_len, vecs[i].mode);
         vecs[i].exp_lat    = (vecs[i].msg_len == 0) ? 8*RPC + 1 : 9*RPC + 1;
      end

      rst = 1'b1; start = 1'b0; msg_len = '0; m_valid = 1'b0; m_data = '0; m_keep = '0;
      start4 = 1'b0; msg_len4 = '0; m_valid4 = 1'b0; m_data4 = '0; m_keep4 = '0;
      repeat (3) @(negedge clk);
      check("reset_m_ready",    {63'd0, m_ready},    64'd0);
      check("reset_busy",       {63'd0, busy},       64'd0);
      check("reset_hash_ready", {63'd0, hash_ready}, 64'd0);
      check("reset_len_err",    {63'd0, len_err},    64'd0);
      check("reset_digest",     64'(digest),         64'd0);
      check("reset_busy4",      {63'd0, busy4},      64'd0);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         run_msg(vecs[i].msg_len, vecs[i].mode, vecs[i].gap, dig, lat, err, mr_seen, start_ok);
         digs[i] = dig;
         $display("msg len=%0d mode=%0d gap=%0d digest=%08h latency=%0d len_err=%0b",
                  vecs[i].msg_len, vecs[i].mode, vecs[i].gap, dig, lat, err);
         check($sformatf("digest_v%0d", i),  64'(dig), 64'(vecs[i].exp_digest));
         check($sformatf("latency_v%0d", i), 64'(lat), 64'(vecs[i].exp_lat));
         check($sformatf("len_err_v%0d", i), {63'd0, err}, 64'd0);
         check($sformatf("start_drop_v%0d", i), {63'd0, start_ok}, 64'd1);
         if (vecs[i].msg_len == 0)
            check("empty_m_ready_seen", {63'd0, mr_seen}, 64'd0);
      end
      check("A_differs_from_empty", {63'd0, digs[1] != digs[0]}, 64'd1);
      check("gap_digest_same",      64'(digs[3]), 64'(digs[2]));
      check("len49_differs",        {63'd0, digs[4] != digs[2]}, 64'd1);

      // start is ignored while a message is in progress
      @(negedge clk);
      start = 1'b1; msg_len = 64'd1;
      @(negedge clk);
      start = 1'b1; msg_len = 64'd0;
      @(negedge clk);
      start = 1'b0;
      check("start_ignored_ready", {63'd0, m_ready}, 64'd1);
      send_byte(8'h41, 0);
      start = 1'b1; msg_len = 64'd5;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, mr_seen);
      $display("msg start-ignored digest=%08h", digest);
      check("start_ignored_digest", 64'(digest), 64'(golden(1, 1)));

      // reset in the middle of COMPRESS aborts the message
      @(negedge clk);
      start = 1'b1; msg_len = 64'd50;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) send_byte(8'(i), 0);
      check("mid_compress_state", {62'd0, busy, m_ready}, 64'd2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_outputs", {30'd0, m_ready, busy, hash_ready, len_err, digest}, 64'd0);
      run_msg(1, 1, 0, dig, lat, err, mr_seen, start_ok);
      $display("msg after-reset digest=%08h latency=%0d", dig, lat);
      check("after_reset_digest",  64'(dig), 64'(golden(1, 1)));
      check("after_reset_latency", 64'(lat), 64'(9*RPC + 1));

      // four-byte beats: over-long last beat clips and flags, exact one does not
      run4(1'b1, 1'b0, dig, lat, err_now, err, rdy);
      $display("msg4 keep=1111 digest=%08h latency=%0d len_err=%0b", dig, lat, err);
      check("bpb4_full_digest",   64'(dig), 64'(golden(50, 0)));
      check("bpb4_full_latency",  64'(lat), 64'(10*RPC + 1));
      check("bpb4_full_err_next", {63'd0, err_now}, 64'd1);
      check("bpb4_full_err_end",  {63'd0, err}, 64'd1);
      check("bpb4_vs_bpb1",       64'(dig), 64'(digs[2]));
      run4(1'b0, 1'b1, dig, lat, err_now, err, rdy);
      $display("msg4 keep=0011 digest=%08h latency=%0d len_err=%0b", dig, lat, err);
      check("bpb4_exact_digest",  64'(dig), 64'(golden(50, 0)));
      check("bpb4_exact_err",     {63'd0, err}, 64'd0);
      check("bpb4_empty_beat_rdy", {63'd0, rdy}, 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
